// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: word-organised data memory request/acknowledge bus
interface dmem_access_unit_if;
  logic        DM_READ;
  logic        DM_WRITE;
  logic [29:0] DM_ADDR;
  logic [31:0] DM_WDATA;
  logic [3:0]  DM_BYTE_EN;
  logic [31:0] DM_RDATA;
  logic        DM_ACK;
  modport master(output DM_READ, DM_WRITE, DM_ADDR, DM_WDATA, DM_BYTE_EN, input DM_RDATA, DM_ACK);
  modport slave(input DM_READ, DM_WRITE, DM_ADDR, DM_WDATA, DM_BYTE_EN, output DM_RDATA, DM_ACK);
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: memory-stage load/store formatter and data memory handshake with pipeline stall
module dmem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       MEM_READ,
  input  logic                       MEM_WRITE,
  input  logic [2:0]                 FUNCT3,
  input  logic [31:0]                ADDRESS,
  input  logic [31:0]                WRITE_DATA,
  output logic                       BUSYWAIT,
  output logic [31:0]                DMEM_OUT,
  output logic                       ACCESS_FAULT,
  dmem_access_unit_if.master         dm
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic [2:0] f3;
  logic [1:0] lane;
  logic [31:0] cnt, ld, st_data;
  logic [7:0] b;
  logic [15:0] h;
  logic [3:0] st_en;
  logic fault, legal, aligned, valid, expired, start, finish;
  always_comb begin
    legal = FUNCT3 inside {3'b000, 3'b001, 3'b010} || (MEM_READ && FUNCT3 inside {3'b100, 3'b101});
    aligned = FUNCT3[1:0] == 2'b01 ? !ADDRESS[0] : FUNCT3[1:0] == 2'b10 ? ADDRESS[1:0] == 2'b00 : 1'b1;
    valid = (MEM_READ ^ MEM_WRITE) && legal && aligned;
    expired = ACK_TIMEOUT != 0 && cnt == 32'(ACK_TIMEOUT - 1);
    start = state == IDLE && valid;
    finish = state == ACCESS && (dm.DM_ACK || expired);
    state_n = start ? ACCESS : finish ? DONE : state == ACCESS ? ACCESS : IDLE;
    b = dm.DM_RDATA[8*lane +: 8];
    h = dm.DM_RDATA[16*lane[1] +: 16];
    ld = f3[1:0] == 2'b00 ? {{24{b[7] & !f3[2]}}, b} : f3[1:0] == 2'b01 ? {{16{h[15] & !f3[2]}}, h} : dm.DM_RDATA;
    st_en = FUNCT3[1:0] == 2'b00 ? 4'b0001 << ADDRESS[1:0] : FUNCT3[1:0] == 2'b01 ? 4'b0011 << ADDRESS[1:0] : 4'b1111;
    st_data = FUNCT3[1:0] == 2'b00 ? {4{WRITE_DATA[7:0]}} : FUNCT3[1:0] == 2'b01 ? {2{WRITE_DATA[15:0]}} : WRITE_DATA;
    BUSYWAIT = !RESET && (start || state == ACCESS);
    ACCESS_FAULT = !RESET && (fault || (state == IDLE && (MEM_READ || MEM_WRITE) && !valid));
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      f3 <= '0;
      lane <= '0;
      fault <= 1'b0;
      DMEM_OUT <= '0;
      dm.DM_READ <= 1'b0;
      dm.DM_WRITE <= 1'b0;
      dm.DM_ADDR <= '0;
      dm.DM_WDATA <= '0;
      dm.DM_BYTE_EN <= '0;
    end else begin
      state <= state_n;
      fault <= finish && !dm.DM_ACK;
      cnt <= state == ACCESS ? cnt + 32'd1 : '0;
      if (start) begin
        f3 <= FUNCT3;
        lane <= ADDRESS[1:0];
        dm.DM_READ <= MEM_READ;
        dm.DM_WRITE <= MEM_WRITE;
        dm.DM_ADDR <= ADDRESS[31:2];
        dm.DM_WDATA <= st_data;
        dm.DM_BYTE_EN <= MEM_WRITE ? st_en : 4'b1111;
      end
      if (finish) begin
        DMEM_OUT <= dm.DM_ACK && dm.DM_READ ? ld : '0;
        dm.DM_READ <= 1'b0;
        dm.DM_WRITE <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: randomized scoreboard bench for dmem_access_unit against a behavioural model
module tb_dmem_access_unit;
  logic CLK = 0, RESET = 1, MEM_READ = 0, MEM_WRITE = 0;
  logic [2:0] FUNCT3 = 0;
  logic [31:0] ADDRESS = 0, WRITE_DATA = 0;
  logic BUSYWAIT, ACCESS_FAULT;
  logic [31:0] DMEM_OUT;
  dmem_access_unit_if dif();
  dmem_access_unit #(.ACK_TIMEOUT(8)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .FUNCT3(FUNCT3),
    .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA), .BUSYWAIT(BUSYWAIT), .DMEM_OUT(DMEM_OUT),
    .ACCESS_FAULT(ACCESS_FAULT), .dm(dif)
  );
  always #5 CLK = ~CLK;

  typedef struct {
    logic inv; logic [31:0] out; logic flt; int busy;
    logic [29:0] addr; logic [3:0] be; logic [31:0] wdata; logic wr;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, lat = 0;
  logic [31:0] mem_word = 0;
  logic mon_en = 0, mem_en = 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic exp_t model(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, wd, word, input int l);
    exp_t e;
    int size = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    logic [31:0] v, mask;
    e = '{default: '0};
    e.inv = (rd && wr) || f3[1:0] == 2'b11 || (f3[2] && (wr || f3[1])) || (a % size) != 0;
    if (e.inv) return e;
    mask = size == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 1;
    v = (word >> (8 * (a % 4))) & mask;
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
    e.wr = wr;
    e.addr = a[31:2];
    e.be = wr ? 4'((32'd1 << size) - 1) << (a % 4) : 4'hF;
    e.wdata = size == 1 ? wd[7:0] * 32'h0101_0101 : size == 2 ? wd[15:0] * 32'h0001_0001 : wd;
    e.flt = l < 1 || l > 8;
    e.busy = e.flt ? 9 : l + 1;
    e.out = (e.flt || wr) ? 32'd0 : v;
    return e;
  endfunction

  initial begin
    dif.DM_ACK = 0;
    dif.DM_RDATA = 0;
    forever begin
      int k;
      @(posedge CLK); #1;
      if (mem_en) begin
        dif.DM_ACK = 0;
        if (dif.DM_READ || dif.DM_WRITE) begin
          k++;
          if (k == lat) begin
            dif.DM_ACK = 1;
            dif.DM_RDATA = mem_word;
          end
        end else k = 0;
      end
    end
  end

  initial begin
    int busy = 0;
    logic seen = 0, cwr = 0;
    logic [29:0] caddr = 0;
    logic [3:0] cbe = 0;
    logic [31:0] cwd = 0;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (busy == 0) chk("idle_no_req", {31'd0, dif.DM_READ | dif.DM_WRITE}, 0);
        if (dif.DM_READ || dif.DM_WRITE) begin
          if (!seen) begin
            seen = 1; cwr = dif.DM_WRITE; caddr = dif.DM_ADDR; cbe = dif.DM_BYTE_EN; cwd = dif.DM_WDATA;
          end else begin
            chk("hold_addr", {2'b0, dif.DM_ADDR}, {2'b0, caddr});
            chk("hold_be", {28'd0, dif.DM_BYTE_EN}, {28'd0, cbe});
            chk("hold_wdata", dif.DM_WDATA, cwd);
          end
        end
        if (BUSYWAIT) busy++;
        else if (busy > 0 || ACCESS_FAULT) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_response: got busy=%0d fault=%b want none", busy, ACCESS_FAULT);
          end else begin
            e = q.pop_front();
            if (busy == 0) chk("invalid_flag", {31'd0, ACCESS_FAULT}, {31'd0, e.inv});
            else begin
              chk("kind_valid", {31'd0, e.inv}, 0);
              chk("dmem_out", DMEM_OUT, e.out);
              chk("fault_done", {31'd0, ACCESS_FAULT}, {31'd0, e.flt});
              chk("busy_cycles", busy, e.busy);
              chk("req_seen", {31'd0, seen}, 1);
              chk("done_no_req", {31'd0, dif.DM_READ | dif.DM_WRITE}, 0);
              chk("dm_write", {31'd0, cwr}, {31'd0, e.wr});
              chk("dm_addr", {2'b0, caddr}, {2'b0, e.addr});
              chk("dm_byte_en", {28'd0, cbe}, {28'd0, e.be});
              if (e.wr) chk("dm_wdata", cwd, e.wdata);
            end
          end
          busy = 0;
          seen = 0;
        end
      end
    end
  end

  task automatic req(input logic rd, wr, input logic [2:0] f3, input logic [31:0] a, wd, word, input int l);
    int n = 0;
    logic bw;
    q.push_back(model(rd, wr, f3, a, wd, word, l));
    mem_word = word;
    lat = l;
    MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITE_DATA = wd;
    do begin
      @(negedge CLK); bw = BUSYWAIT;
      @(posedge CLK); #1; n++;
    end while (bw && n < 40);
    if (bw) begin
      tests++; fails++;
      $display("FAIL drain: got BUSYWAIT stuck after %0d cycles want release", n);
    end
    MEM_READ = 0; MEM_WRITE = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    MEM_READ = 1; FUNCT3 = 3'b010; ADDRESS = 32'h1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", {31'd0, BUSYWAIT}, 0);
    chk("rst_fault", {31'd0, ACCESS_FAULT}, 0);
    chk("rst_dmem_out", DMEM_OUT, 0);
    chk("rst_dm_req", {30'd0, dif.DM_READ, dif.DM_WRITE}, 0);
    chk("rst_dm_be", {28'd0, dif.DM_BYTE_EN}, 0);
    chk("rst_dm_addr", {2'b0, dif.DM_ADDR}, 0);
    @(posedge CLK); #1;
    MEM_READ = 0; ADDRESS = 0; RESET = 0;
    mon_en = 1;
    @(posedge CLK); #1;
    req(1, 0, 3'b000, 32'h0000_0103, 0, 32'h80FF_1234, 1);
    req(1, 0, 3'b101, 32'h0000_0012, 0, 32'hBEEF_0001, 4);
    req(0, 1, 3'b000, 32'h0000_0021, 32'h1234_56AB, 0, 2);
    req(1, 0, 3'b010, 32'h0000_0006, 0, 0, 1);
    req(1, 0, 3'b010, 32'h0000_0200, 0, 32'hDEAD_BEEF, 0);
    req(1, 1, 3'b010, 32'h0000_0000, 0, 0, 1);
    req(0, 1, 3'b100, 32'h0000_0000, 0, 0, 1);
    req(0, 1, 3'b001, 32'h0000_0042, 32'hCAFE_8765, 0, 3);
    req(1, 0, 3'b001, 32'h0000_0046, 0, 32'h8001_7FFF, 7);
    for (int i = 0; i < 80; i++) begin
      int mode = $urandom_range(0, 7);
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 2) > 0) a = a & ~32'(f3[1:0] == 2'b10 ? 3 : f3[1:0] == 2'b01 ? 1 : 0);
      req(mode == 0 || mode < 5, mode == 0 || mode >= 5, f3, a, $urandom, $urandom, $urandom_range(0, 7));
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("queue_empty", q.size(), 0);
    mon_en = 0;
    mem_en = 0;
    dif.DM_ACK = 0;
    MEM_WRITE = 1; FUNCT3 = 3'b010; ADDRESS = 32'h0000_0080; WRITE_DATA = 32'h5555_AAAA;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1; MEM_WRITE = 0;
    @(posedge CLK); #1;
    RESET = 0;
    chk("midrst_dm_write", {31'd0, dif.DM_WRITE}, 0);
    chk("midrst_busy", {31'd0, BUSYWAIT}, 0);
    chk("midrst_be", {28'd0, dif.DM_BYTE_EN}, 0);
    dif.DM_ACK = 1; dif.DM_RDATA = 32'h1357_9BDF;
    @(posedge CLK); #1;
    dif.DM_ACK = 0;
    chk("late_ack_out", DMEM_OUT, 0);
    chk("late_ack_fault", {31'd0, ACCESS_FAULT}, 0);
    chk("late_ack_req", {30'd0, dif.DM_READ, dif.DM_WRITE}, 0);
    @(posedge CLK); #1;
    chk("late_ack_idle_busy", {31'd0, BUSYWAIT}, 0);
    chk("late_ack_out2", DMEM_OUT, 0);
    mem_en = 1;
    mon_en = 1;
    req(1, 0, 3'b100, 32'h0000_0301, 0, 32'h00C3_9100, 2);
    repeat (3) @(posedge CLK);
    #1;
    chk("queue_empty_end", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
